pack_signed_stream: RTL

- Sequential signed LEB128 encoder; the transmit-side counterpart of the combinational signed LEB128 decoder.
- Accepts one N-bit two's-complement value per handshake.
- Emits its minimal-length signed LEB128 encoding as a byte stream, least-significant group first, one byte per accepted output beat.
- Sits between value producers (e.g. a module/section writer) and a byte-wide output buffer.

---
 rtl/pack_signed_stream.sv | 85 ++++++++
 1 files changed

// File: rtl/pack_signed_stream.sv
// Sequential signed LEB128 encoder: takes one N-bit two's-complement value per
// handshake and streams its minimal-length encoding, least-significant group first.
module pack_signed_stream #(
    parameter int N = 64,
    localparam int MAXB = (N + 6) / 7,
    localparam int IW = (MAXB > 1) ? $clog2(MAXB) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic          out_last,
    output logic [IW-1:0] out_idx
);
    // Shift register is widened to a whole number of groups so the top group
    // picks up sign-extension bits when N is not a multiple of 7.
    localparam int SW = MAXB * 7;

    typedef enum logic {S_IDLE, S_EMIT} state_t;

    state_t               state_q, state_d;
    logic signed [SW-1:0] sh_q, sh_d;
    logic [IW-1:0]        idx_q, idx_d;

    logic [6:0]           grp;
    logic signed [SW-1:0] rest;
    logic                 done;

    always_comb begin
        grp  = sh_q[6:0];
        rest = sh_q >>> 7;
        done = ((rest == '0) && !grp[6]) || ((rest == '1) && grp[6]);
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_EMIT;
                    sh_d    = SW'($signed(in_data));
                    idx_d   = '0;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (done) begin
                        state_d = S_IDLE;
                    end else begin
                        sh_d  = rest;
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
        end
    end

    // Outputs derive only from registered state; byte fields read as zero when idle.
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_EMIT);
        out_data  = out_valid ? {~done, grp} : 8'h00;
        out_last  = out_valid && done;
        out_idx   = idx_q;
    end
endmodule
